write_request_assembler: RTL and testbench
==========================================

# write_request_assembler

Front-end write path of the memory controller. Accepts AXI write-address (AW) and write-data (W) channels from the cache side and decodes each AW address into a `mem_addr_t` and a one-hot RankFSM select. It then pairs every AW with exactly `BURST_LENGTH` W beats and forwards each beat, tagged with its address, id and user, to the selected RankFSM through a registered valid/ready output stage.

## Interface
- `DEPTH`, default `ASSEMBLER_DEPTH` (8): AW entry FIFO depth; must be a power of two.
- `BEATS`, default `BURST_LENGTH` (8): W beats per write request.
- `clk`, in, 1: sole clock; all state is rising-edge.
- `rst_n`, in, 1: reset, **asynchronous, active-low**.
- `aw_i`, in, `axi_aw_chan_t`: write address, id, user.
- `aw_valid_i`, in, 1; `aw_ready_o`, out, 1: AW handshake.
- `w_i`, in, `axi_w_chan_t`: write data, strobe, last.
- `w_valid_i`, in, 1; `w_ready_o`, out, 1: W handshake.
- `req_mem_addr_o`, out, `mem_addr_t`: decoded address of the current burst.
- `req_addr_o`, out, `AXI_ADDRWIDTH`: original AXI address.
- `req_id_o`, out, `MEM_IDWIDTH`; `req_user_o`, out, `MEM_USERWIDTH`: AW id and user.
- `req_data_o`, out, `MEM_DATAWIDTH`; `req_strb_o`, out, `MEM_DATAWIDTH/8`: beat payload.
- `req_last_o`, out, 1: high on the beat with index `BEATS-1`.
- `req_valid_o`, out, `NUM_FSM`: one-hot RankFSM select; all-zero when no beat is held.
- `req_data_valid_o`, out, 1: output register holds a beat.
- `fsm_aw_ready_i`, in, `NUM_FSM`; `fsm_w_ready_i`, in, `NUM_FSM`: per-RankFSM readiness.
- `wlast_err_o`, out, 1: one-cycle pulse when an accepted beat's `w_i.last` disagrees with the beat count.

## Operation
- **Address decode.** `mem_addr` is `aw_i.addr` bit-cast onto `mem_addr_t`, with `col[2:0]` forced to 0. The FSM index is `{channel, rank}` (3 bits); `fsm = 1 << index`.
- **AW FIFO.** An AW is pushed on `aw_valid_i & aw_ready_o`. `aw_ready_o = ~full & init_done`. There is no bypass: an AW pushed at cycle t is visible at the head at t+1. When the FIFO is full, a simultaneous pop does not raise `aw_ready_o` in the same cycle.
- **Burst FSM, IDLE state.** Entered when the FIFO is empty. `w_ready_o = 0`.
- **Burst FSM, BURST state.** Entered when the head entry is valid. `beat_cnt` runs 0..`BEATS-1`. `w_ready_o = init_done & (~out_valid | out_fire)`.
- **Beat acceptance.** A beat is accepted on `w_valid_i & w_ready_o`. It is loaded into the output register together with the head entry's fields, `req_last_o = (beat_cnt == BEATS-1)` and `req_valid_o = head.fsm`. `beat_cnt` then increments.
- **Burst termination.** On the accepted beat with `beat_cnt == BEATS-1`, the head is popped and `beat_cnt` clears. The FSM moves to BURST if another entry remains, otherwise to IDLE. The burst length comes only from the count; `w_i.last` never ends a burst.
- **Last-flag check.** `wlast_err_o` pulses in the cycle after acceptance when `w_i.last != (beat_cnt == BEATS-1)`.
- **Output transfer.** `out_fire = out_valid & fsm_w_ready_i[idx] & (first_beat ? fsm_aw_ready_i[idx] : 1)`, where `first_beat` means the held beat has index 0.
- **Stall.** If the output is held and not firing, the register keeps its value and `w_ready_o = 0`.
- **Constant fields.** Downstream `write` is implied as 1; this block carries no read fields.

## Timing
- **Reset values.** Every output is 0 while `rst_n` is low, including `aw_ready_o`, `w_ready_o` and `req_valid_o`. FIFO pointers, count, `beat_cnt` and `out_valid` clear, and the FSM goes to IDLE.
- **Reset release.** The `init_done` flop sets on the first edge after release; `aw_ready_o` rises 1 cycle after release.
- **Latency.** AW at t and W beat 0 at t+1 (earliest) give the output beat at t+2.
- **Throughput.** One beat per cycle when the target FSM is ready continuously; a full burst takes `BEATS` consecutive cycles.
- **Wrap-around.** FIFO pointers wrap modulo `DEPTH`. Count width is `$clog2(DEPTH)+1`.
- **Reset mid-burst.** The partial burst is discarded entirely; no output is held.

## Structure
- Package `MemoryController_Definitions` supplies `axi_aw_chan_t`, `axi_w_chan_t`, `mem_addr_t`, `WrAddrEntry`, `ASSEMBLER_DEPTH`, `BURST_LENGTH`, `NUM_FSM` and `NUM_FSM_BIT`.
- Add `ASSEMBLER_BEATCNT_W = $clog2(BURST_LENGTH)` to that package.
- One sub-module: `assembler_addr_fifo`, a `WrAddrEntry` FIFO with push/pop/full/empty/head. The burst FSM and output register stay in the top module.

## Test plan
- **Single burst.** After reset, AW addr `0x8000_0040` (channel 1, rank 0), then 8 W beats back-to-back with the last flag on beat 7. Expect `req_valid_o = 8'b0001_0000` on 8 consecutive cycles starting at t+2, `req_last_o` only on beat 7, `col[2:0] = 0`, and `wlast_err_o` never asserted.
- **W before AW.** `w_valid_i` is held high with no AW. Expect `w_ready_o = 0`; it rises 1 cycle after an AW is accepted.
- **FIFO full.** 8 AWs with no W. Expect `aw_ready_o = 0` after the 8th. A completed burst re-asserts `aw_ready_o` on the following cycle; the 9th AW is then accepted.
- **Backpressure.** `fsm_aw_ready_i[idx] = 0` while beat 0 is held. Expect the output to stay stable, `w_ready_o = 0`, and no beat lost. Release; beat 0 then fires and beats 1..7 follow at one per cycle.
- **Early last.** `w_i.last = 1` on beat 3. Expect a `wlast_err_o` pulse, the burst still ending on beat 7, and the next AW unaffected.
- **Reset mid-burst.** Assert `rst_n = 0` after beat 4. Expect all outputs 0 during reset, then a clean IDLE with an empty FIFO after release.

Source files
------------

// File: rtl/write_request_assembler_pkg.sv
// Shared types and sizing for the memory-controller write path: AXI channel
// payloads, the decoded DRAM address and the AW entry queued by the assembler.
package MemoryController_Definitions;
  localparam int AXI_ADDRWIDTH       = 32;
  localparam int MEM_IDWIDTH         = 4;
  localparam int MEM_USERWIDTH       = 4;
  localparam int MEM_DATAWIDTH       = 64;
  localparam int NUM_FSM             = 8;
  localparam int NUM_FSM_BIT         = $clog2(NUM_FSM);
  localparam int ASSEMBLER_DEPTH     = 8;
  localparam int BURST_LENGTH        = 8;
  localparam int ASSEMBLER_BEATCNT_W = $clog2(BURST_LENGTH);

  typedef struct packed {
    logic [AXI_ADDRWIDTH-1:0] addr;
    logic [MEM_IDWIDTH-1:0]   id;
    logic [MEM_USERWIDTH-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [MEM_DATAWIDTH-1:0]   data;
    logic [MEM_DATAWIDTH/8-1:0] strb;
    logic                       last;
  } axi_w_chan_t;

  // MSB-first overlay of the AXI address; {channel, rank} picks the RankFSM.
  typedef struct packed {
    logic [0:0]  channel;
    logic [1:0]  rank;
    logic [1:0]  bg;
    logic [1:0]  bank;
    logic [14:0] row;
    logic [9:0]  col;
  } mem_addr_t;

  typedef struct packed {
    mem_addr_t                mem_addr;
    logic [AXI_ADDRWIDTH-1:0] addr;
    logic [MEM_IDWIDTH-1:0]   id;
    logic [MEM_USERWIDTH-1:0] user;
    logic [NUM_FSM-1:0]       fsm;
  } WrAddrEntry;

  function automatic logic [NUM_FSM-1:0] fsm_select(input mem_addr_t a);
    logic [NUM_FSM_BIT-1:0] idx;
    idx = {a.channel, a.rank};
    return NUM_FSM'(1) << idx;
  endfunction
endpackage

// File: rtl/write_request_assembler_addr_fifo.sv
// Circular FIFO of decoded AW entries; head is registered storage, so a push
// becomes visible one cycle later and full/empty come straight from the count.
module assembler_addr_fifo
  import MemoryController_Definitions::*;
#(
  parameter int DEPTH = ASSEMBLER_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  WrAddrEntry             entry_i,
  input  logic                   pop_i,
  output WrAddrEntry             head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);

  WrAddrEntry     mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    count_q;
  logic           push_ok, pop_ok;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= entry_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/write_request_assembler.sv
// Pairs each queued AW with a fixed-length W burst and presents every beat,
// tagged with its address/id/user, to the selected RankFSM via one output register.
module write_request_assembler
  import MemoryController_Definitions::*;
#(
  parameter int DEPTH = ASSEMBLER_DEPTH,
  parameter int BEATS = BURST_LENGTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  axi_aw_chan_t                 aw_i,
  input  logic                         aw_valid_i,
  output logic                         aw_ready_o,
  input  axi_w_chan_t                  w_i,
  input  logic                         w_valid_i,
  output logic                         w_ready_o,
  output mem_addr_t                    req_mem_addr_o,
  output logic [AXI_ADDRWIDTH-1:0]     req_addr_o,
  output logic [MEM_IDWIDTH-1:0]       req_id_o,
  output logic [MEM_USERWIDTH-1:0]     req_user_o,
  output logic [MEM_DATAWIDTH-1:0]     req_data_o,
  output logic [MEM_DATAWIDTH/8-1:0]   req_strb_o,
  output logic                         req_last_o,
  output logic [NUM_FSM-1:0]           req_valid_o,
  output logic                         req_data_valid_o,
  input  logic [NUM_FSM-1:0]           fsm_aw_ready_i,
  input  logic [NUM_FSM-1:0]           fsm_w_ready_i,
  output logic                         wlast_err_o
);
  localparam int CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              beat_cnt_q, beat_cnt_d;
  logic                       init_done_q, wlast_err_q;
  logic                       out_valid_q, out_first_q, out_last_q;
  WrAddrEntry                 out_ent_q;
  logic [MEM_DATAWIDTH-1:0]   out_data_q;
  logic [MEM_DATAWIDTH/8-1:0] out_strb_q;

  WrAddrEntry       entry, head;
  mem_addr_t        dec_addr;
  logic             full, empty;
  logic [CNTW-1:0]  count;
  logic             aw_push, w_accept, is_last, burst_done, out_fire;
  logic [NUM_FSM-1:0] fire_gate;

  always_comb begin
    dec_addr          = mem_addr_t'(aw_i.addr);
    dec_addr.col[2:0] = 3'b0;
    entry = '{mem_addr: dec_addr, addr: aw_i.addr, id: aw_i.id,
              user: aw_i.user, fsm: fsm_select(dec_addr)};
  end

  assign aw_ready_o = ~full & init_done_q;
  assign aw_push    = aw_valid_i & aw_ready_o;

  // Beat 0 opens a new request downstream, so it also needs the AW-side ready.
  assign fire_gate  = fsm_w_ready_i & (out_first_q ? fsm_aw_ready_i : {NUM_FSM{1'b1}});
  assign out_fire   = out_valid_q & |(out_ent_q.fsm & fire_gate);
  assign w_ready_o  = (state_q == BURST) & init_done_q & (~out_valid_q | out_fire);
  assign w_accept   = w_valid_i & w_ready_o;
  assign is_last    = (beat_cnt_q == LAST_BEAT);
  assign burst_done = w_accept & is_last;

  assembler_addr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (aw_push),
    .entry_i (entry),
    .pop_i   (burst_done),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (w_accept) beat_cnt_d = is_last ? '0 : beat_cnt_q + CW'(1);
    case (state_q)
      IDLE:    if (aw_push || !empty) state_d = BURST;
      BURST:   if (burst_done && count == CNTW'(1) && !aw_push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      init_done_q <= 1'b0;
      wlast_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ent_q   <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
    end else begin
      init_done_q <= 1'b1;
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      wlast_err_q <= w_accept & (w_i.last != is_last);
      if (w_accept) begin
        out_valid_q <= 1'b1;
        out_first_q <= (beat_cnt_q == '0);
        out_last_q  <= is_last;
        out_ent_q   <= head;
        out_data_q  <= w_i.data;
        out_strb_q  <= w_i.strb;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign req_mem_addr_o   = out_ent_q.mem_addr;
  assign req_addr_o       = out_ent_q.addr;
  assign req_id_o         = out_ent_q.id;
  assign req_user_o       = out_ent_q.user;
  assign req_data_o       = out_data_q;
  assign req_strb_o       = out_strb_q;
  assign req_last_o       = out_last_q;
  assign req_valid_o      = out_valid_q ? out_ent_q.fsm : '0;
  assign req_data_valid_o = out_valid_q;
  assign wlast_err_o      = wlast_err_q;
endmodule

// File: tb/tb_write_request_assembler.sv
// Directed + randomized bench for write_request_assembler against a queue-based
// model of AW/W pairing, output holding and downstream readiness.
module tb_write_request_assembler;
  import MemoryController_Definitions::*;
  localparam int DEPTH = ASSEMBLER_DEPTH;
  localparam int BEATS = BURST_LENGTH;

  logic clk = 1'b0, rst_n = 1'b0;
  axi_aw_chan_t aw_i;
  axi_w_chan_t  w_i;
  logic aw_valid_i, aw_ready_o, w_valid_i, w_ready_o;
  mem_addr_t req_mem_addr_o;
  logic [AXI_ADDRWIDTH-1:0]   req_addr_o;
  logic [MEM_IDWIDTH-1:0]     req_id_o;
  logic [MEM_USERWIDTH-1:0]   req_user_o;
  logic [MEM_DATAWIDTH-1:0]   req_data_o;
  logic [MEM_DATAWIDTH/8-1:0] req_strb_o;
  logic req_last_o, req_data_valid_o, wlast_err_o;
  logic [NUM_FSM-1:0] req_valid_o, fsm_aw_ready_i, fsm_w_ready_i;

  write_request_assembler dut (
    .clk(clk), .rst_n(rst_n),
    .aw_i(aw_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_i(w_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .req_mem_addr_o(req_mem_addr_o), .req_addr_o(req_addr_o),
    .req_id_o(req_id_o), .req_user_o(req_user_o),
    .req_data_o(req_data_o), .req_strb_o(req_strb_o), .req_last_o(req_last_o),
    .req_valid_o(req_valid_o), .req_data_valid_o(req_data_valid_o),
    .fsm_aw_ready_i(fsm_aw_ready_i), .fsm_w_ready_i(fsm_w_ready_i),
    .wlast_err_o(wlast_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_FSM-1:0]         fsm;
    logic [AXI_ADDRWIDTH-1:0]   maddr, addr;
    logic [MEM_IDWIDTH-1:0]     id;
    logic [MEM_USERWIDTH-1:0]   user;
    logic [MEM_DATAWIDTH-1:0]   data;
    logic [MEM_DATAWIDTH/8-1:0] strb;
    logic                       last, first;
  } beat_t;

  axi_aw_chan_t aw_src[$], aw_m[$];
  axi_w_chan_t  w_src[$];
  beat_t        held_q[$];
  int  model_beat = 0;
  bit  init_m = 0, err_m = 0, rnd_mode = 0;
  int  total = 0, bad = 0, cyc_n = 0;
  int  fired_n, err_n, w_acc_n, first_fire_cyc, last_fire_cyc, aw_acc_cyc, first_wacc_cyc;
  logic [NUM_FSM-1:0] last_fsm;
  logic [2:0] col_or;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    fired_n = 0; err_n = 0; w_acc_n = 0; col_or = '0; last_fsm = '0;
    first_fire_cyc = -1; last_fire_cyc = -1; aw_acc_cyc = -1; first_wacc_cyc = -1;
  endtask

  task automatic model_reset();
    aw_src.delete(); aw_m.delete(); w_src.delete(); held_q.delete();
    model_beat = 0; err_m = 0; init_m = 0;
  endtask

  task automatic add_aw(input logic [31:0] addr);
    axi_aw_chan_t a;
    a.addr = addr; a.id = MEM_IDWIDTH'($urandom); a.user = MEM_USERWIDTH'($urandom);
    aw_src.push_back(a);
  endtask

  task automatic add_burst_w(input int mask);
    axi_w_chan_t w;
    for (int i = 0; i < BEATS; i++) begin
      w.data = {$urandom, $urandom};
      w.strb = (MEM_DATAWIDTH/8)'($urandom);
      w.last = mask[i];
      w_src.push_back(w);
    end
  endtask

  // One clock: drive sources, check outputs against the model, advance the model.
  task automatic cyc();
    beat_t b, nb;
    logic fire, held, exp_awr, exp_wr;
    logic [NUM_FSM-1:0] gate;
    int idx;
    if (rnd_mode) begin
      fsm_w_ready_i  = NUM_FSM'($urandom | $urandom);
      fsm_aw_ready_i = NUM_FSM'($urandom | $urandom);
    end
    aw_valid_i = rst_n && aw_src.size() > 0;
    if (aw_valid_i) aw_i = aw_src[0];
    w_valid_i = rst_n && w_src.size() > 0 && (!rnd_mode || $urandom_range(3) != 0);
    if (w_valid_i) w_i = w_src[0];
    #4;
    if (!rst_n) begin
      chk("rst_aw_ready", aw_ready_o, 1'b0);
      chk("rst_w_ready", w_ready_o, 1'b0);
      chk("rst_req_valid", req_valid_o, '0);
      chk("rst_data_valid", req_data_valid_o, 1'b0);
      chk("rst_last", req_last_o, 1'b0);
      chk("rst_wlast_err", wlast_err_o, 1'b0);
      chk("rst_req_data", req_data_o, '0);
      chk("rst_req_addr", req_addr_o, '0);
    end else begin
      held = held_q.size() > 0;
      fire = 1'b0;
      if (held) begin
        b = held_q[0];
        gate = fsm_w_ready_i & (b.first ? fsm_aw_ready_i : {NUM_FSM{1'b1}});
        fire = |(gate & b.fsm);
      end
      exp_awr = init_m && aw_m.size() < DEPTH;
      exp_wr  = init_m && aw_m.size() > 0 && (!held || fire);
      chk("aw_ready", aw_ready_o, exp_awr);
      chk("w_ready", w_ready_o, exp_wr);
      chk("data_valid", req_data_valid_o, held);
      chk("wlast_err", wlast_err_o, err_m);
      chk("req_valid", req_valid_o, held ? b.fsm : '0);
      if (held) begin
        chk("req_addr", req_addr_o, b.addr);
        chk("req_mem_addr", req_mem_addr_o, b.maddr);
        chk("req_id", req_id_o, b.id);
        chk("req_user", req_user_o, b.user);
        chk("req_data", req_data_o, b.data);
        chk("req_strb", req_strb_o, b.strb);
        chk("req_last", req_last_o, b.last);
      end
      if (wlast_err_o === 1'b1) err_n++;
      if (fire) begin
        if (fired_n == 0) first_fire_cyc = cyc_n;
        last_fire_cyc = cyc_n;
        last_fsm = req_valid_o;
        col_or |= req_mem_addr_o.col[2:0];
        fired_n++;
        void'(held_q.pop_front());
      end
      err_m = 1'b0;
      if (w_valid_i && w_ready_o) begin
        void'(w_src.pop_front());
        if (w_acc_n == 0) first_wacc_cyc = cyc_n;
        w_acc_n++;
        if (aw_m.size() > 0) begin
          idx = 4 * int'(aw_m[0].addr[31]) + int'(aw_m[0].addr[30:29]);
          nb.addr  = aw_m[0].addr;
          nb.maddr = aw_m[0].addr & ~32'h7;
          nb.fsm   = NUM_FSM'(1) << idx;
          nb.id    = aw_m[0].id;
          nb.user  = aw_m[0].user;
          nb.data  = w_i.data;
          nb.strb  = w_i.strb;
          nb.first = (model_beat == 0);
          nb.last  = (model_beat == BEATS - 1);
          err_m    = (w_i.last != nb.last);
          held_q.push_back(nb);
          model_beat++;
          if (nb.last) begin
            model_beat = 0;
            void'(aw_m.pop_front());
          end
        end
      end
      if (aw_valid_i && aw_ready_o) begin
        aw_m.push_back(aw_src.pop_front());
        aw_acc_cyc = cyc_n;
      end
    end
    @(posedge clk);
    if (rst_n) init_m = 1'b1;
    cyc_n++;
    #1;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((aw_src.size() + w_src.size() + held_q.size() + aw_m.size()) != 0 && n < maxc) begin
      cyc();
      n++;
    end
    chk("drain_left", aw_src.size() + w_src.size() + held_q.size() + aw_m.size(), 0);
    cyc(); cyc();
  endtask

  initial begin
    logic [MEM_DATAWIDTH-1:0] bp_data0;
    aw_i = '0; w_i = '0; aw_valid_i = 1'b0; w_valid_i = 1'b0;
    fsm_aw_ready_i = '1; fsm_w_ready_i = '1;
    clr();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc(); cyc();

    // single burst to channel 1 / rank 0
    clr();
    add_aw(32'h8000_0040);
    add_burst_w(1 << (BEATS - 1));
    drain(100);
    chk("single_fired", fired_n, BEATS);
    chk("single_latency", first_fire_cyc - aw_acc_cyc, 2);
    chk("single_back2back", last_fire_cyc - first_fire_cyc, BEATS - 1);
    chk("single_fsm", last_fsm, 8'b0001_0000);
    chk("single_col", col_or, 3'b0);
    chk("single_wlast_err", err_n, 0);

    // W presented before any AW
    clr();
    add_burst_w(1 << (BEATS - 1));
    repeat (3) cyc();
    chk("wfirst_w_ready", w_ready_o, 1'b0);
    chk("wfirst_none_taken", w_acc_n, 0);
    add_aw($urandom);
    drain(100);
    chk("wfirst_rise", first_wacc_cyc - aw_acc_cyc, 1);
    chk("wfirst_fired", fired_n, BEATS);

    // fill the AW FIFO, then free one slot
    clr();
    for (int i = 0; i <= DEPTH; i++) add_aw($urandom);
    repeat (DEPTH + 2) cyc();
    chk("full_aw_ready", aw_ready_o, 1'b0);
    chk("full_pending", aw_src.size(), 1);
    add_burst_w(1 << (BEATS - 1));
    repeat (BEATS + 4) cyc();
    chk("full_ninth_taken", aw_src.size(), 0);
    for (int i = 0; i < DEPTH; i++) add_burst_w(1 << (BEATS - 1));
    drain(400);
    chk("full_fired", fired_n, (DEPTH + 1) * BEATS);

    // downstream AW-side backpressure on beat 0
    clr();
    fsm_aw_ready_i = '0;
    add_aw($urandom);
    add_burst_w(1 << (BEATS - 1));
    bp_data0 = w_src[0].data;
    repeat (6) cyc();
    chk("bp_held", req_data_valid_o, 1'b1);
    chk("bp_w_ready", w_ready_o, 1'b0);
    chk("bp_data", req_data_o, bp_data0);
    chk("bp_none_fired", fired_n, 0);
    fsm_aw_ready_i = '1;
    drain(100);
    chk("bp_fired", fired_n, BEATS);
    chk("bp_back2back", last_fire_cyc - first_fire_cyc, BEATS - 1);

    // early last flag on beat 3, next burst clean
    clr();
    add_aw($urandom); add_aw($urandom);
    add_burst_w((1 << 3) | (1 << (BEATS - 1)));
    add_burst_w(1 << (BEATS - 1));
    drain(100);
    chk("early_err_pulses", err_n, 1);
    chk("early_fired", fired_n, 2 * BEATS);

    // reset in the middle of a burst
    clr();
    add_aw($urandom);
    add_burst_w(1 << (BEATS - 1));
    repeat (6) cyc();
    rst_n = 1'b0;
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("mid_rst_data_valid", req_data_valid_o, 1'b0);
    chk("mid_rst_req_valid", req_valid_o, '0);
    chk("mid_rst_w_ready", w_ready_o, 1'b0);
    chk("mid_rst_aw_ready", aw_ready_o, 1'b1);
    clr();
    add_aw($urandom);
    add_burst_w(1 << (BEATS - 1));
    drain(100);
    chk("post_rst_fired", fired_n, BEATS);
    chk("post_rst_wlast_err", err_n, 0);

    // randomized traffic with random readiness and W gaps
    clr();
    rnd_mode = 1;
    for (int k = 0; k < 20; k++) begin
      add_aw($urandom);
      if ($urandom_range(5) == 0) add_burst_w(1 << $urandom_range(BEATS - 1));
      else add_burst_w(1 << (BEATS - 1));
    end
    drain(4000);
    rnd_mode = 0;
    fsm_aw_ready_i = '1; fsm_w_ready_i = '1;
    chk("rnd_fired", fired_n, 20 * BEATS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
